// File: rtl/btn_poll_master.sv
// Avalon-MM read master that polls a button PIO, debounces bit 0 and emits level/press/release.
// Optional irq/irq_ack ports are enabled by defining BTN_POLL_IRQ_EN.
module btn_poll_master #(
    parameter int         POLL_PERIOD    = 50000,
    parameter int         READ_LATENCY   = 1,
    parameter int         DEBOUNCE_COUNT = 4,
    parameter logic [1:0] POLL_ADDR      = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        btn_level,
    output logic        btn_press,
    output logic        btn_release,
`ifdef BTN_POLL_IRQ_EN
    output logic        irq,
    input  logic        irq_ack,
`endif
    output logic        overrun
);

    localparam int TIMER_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int STABLE_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam int LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [TIMER_W-1:0]  TIMER_MAX   = TIMER_W'(POLL_PERIOD - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_COUNT - 1);
    localparam logic [LAT_W-1:0]    LAT_INIT    = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                read_q, read_d;
    logic [1:0]          address_q, address_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                tick;
    logic                sample;
    logic                unused_readdata;

    assign sample          = avm_readdata[0];
    assign unused_readdata = ^avm_readdata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            stable_q  <= '0;
            lat_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            read_q    <= 1'b0;
            address_q <= 2'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            lat_q     <= lat_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            read_q    <= read_d;
            address_q <= address_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        tick      = (timer_q == TIMER_MAX);
        timer_d   = tick ? '0 : timer_q + TIMER_W'(1);
        state_d   = state_q;
        pending_d = pending_q | tick;
        overrun_d = overrun_q | (tick && (state_q != IDLE));
        lat_d     = lat_q;
        stable_d  = stable_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick on the same edge re-arms pending for the next poll
                if (pending_q) begin
                    state_d   = REQ;
                    pending_d = tick;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    state_d = WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                    if (sample == level_q) begin
                        stable_d = '0;
                    end else if (stable_q == STABLE_LAST) begin
                        level_d   = sample;
                        stable_d  = '0;
                        press_d   = sample;
                        release_d = ~sample;
                    end else begin
                        stable_d = stable_q + STABLE_W'(1);
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        read_d    = (state_d == REQ);
        address_d = read_d ? POLL_ADDR : 2'd0;
    end

`ifdef BTN_POLL_IRQ_EN
    logic irq_q, irq_d;

    // A press wins over a simultaneous acknowledge
    always_comb begin
        irq_d = press_d | (irq_q & ~irq_ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    assign avm_read    = read_q;
    assign avm_address = address_q;
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_btn_poll_master.sv
// Directed bench for btn_poll_master: the bench acts as the button PIO slave and scoreboards debounce results.
// Define BTN_POLL_IRQ_EN to also exercise the irq/irq_ack ports.
module tb_btn_poll_master;

    localparam int         POLL = 8;
    localparam int         LAT  = 1;
    localparam int         DEB  = 3;
    localparam logic [1:0] ADDR = 2'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        waitreq = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        btn_level;
    logic        btn_press;
    logic        btn_release;
    logic        overrun;
`ifdef BTN_POLL_IRQ_EN
    logic        irq;
    logic        irq_ack = 1'b0;
`endif

    typedef struct packed {
        logic lvl;
        logic prs;
        logic rel;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic model_level = 1'b0;
    int   model_cnt   = 0;

    btn_poll_master #(
        .POLL_PERIOD   (POLL),
        .READ_LATENCY  (LAT),
        .DEBOUNCE_COUNT(DEB),
        .POLL_ADDR     (ADDR)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(waitreq),
        .avm_readdata   (rdata),
        .btn_level      (btn_level),
        .btn_press      (btn_press),
        .btn_release    (btn_release),
`ifdef BTN_POLL_IRQ_EN
        .irq            (irq),
        .irq_ack        (irq_ack),
`endif
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the edge count at which avm_read next rises, or -1 on timeout
    task automatic wait_read_rise(output int rise);
        logic prev;
        prev = avm_read;
        rise = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avm_read && !prev) begin
                rise = cyc;
                return;
            end
            prev = avm_read;
        end
    endtask

    // One complete poll with the slave returning bit d
    task automatic apply_stimulus(input logic d, input string tag, output int rise);
        exp_t e;
        exp_t got;
        wait_read_rise(rise);
        check_output({tag, "_seen"}, 32'(rise > 0), 32'd1);
        check_output({tag, "_addr"}, 32'(avm_address), 32'(ADDR));
        rdata = {31'b0, d};
        e = '0;
        if (d == model_level) begin
            model_cnt = 0;
        end else if (model_cnt == DEB - 1) begin
            model_level = d;
            model_cnt   = 0;
            e.prs       = d;
            e.rel       = ~d;
        end else begin
            model_cnt++;
        end
        e.lvl = model_level;
        sb_q.push_back(e);
        @(negedge clk);
        check_output({tag, "_rd_drop"}, 32'(avm_read), 32'd0);
        @(negedge clk);
        got = sb_q.pop_front();
        check_output({tag, "_level"}, 32'(btn_level), 32'(got.lvl));
        check_output({tag, "_press"}, 32'(btn_press), 32'(got.prs));
        check_output({tag, "_release"}, 32'(btn_release), 32'(got.rel));
`ifdef BTN_POLL_IRQ_EN
        if (got.prs) check_output({tag, "_irq_rise"}, 32'(irq), 32'd1);
`endif
        @(negedge clk);
        check_output({tag, "_pulse_end"}, 32'({btn_press, btn_release}), 32'd0);
    endtask

    initial begin
        int r1, r2, r3, r;
        repeat (3) @(negedge clk);
        check_output("reset_state",
                     32'({avm_read, avm_address, btn_level, btn_press, btn_release, overrun}), 32'd0);
        reset_n = 1'b1;

        $display("[TB] polling period");
        apply_stimulus(1'b0, "s1a", r1);
        check_output("s1_first_read", 32'(r1), 32'(POLL + 1));
        apply_stimulus(1'b0, "s1b", r2);
        check_output("s1_period_b", 32'(r2 - r1), 32'(POLL));
        apply_stimulus(1'b0, "s1c", r3);
        check_output("s1_period_c", 32'(r3 - r2), 32'(POLL));
        check_output("s1_overrun", 32'(overrun), 32'd0);

        $display("[TB] press then release");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, "s2_hi", r);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, "s2_lo", r);

        $display("[TB] bouncing input");
        apply_stimulus(1'b1, "s3_1", r);
        apply_stimulus(1'b1, "s3_2", r);
        apply_stimulus(1'b0, "s3_3", r);
        apply_stimulus(1'b1, "s3_4", r);
        apply_stimulus(1'b1, "s3_5", r);
        apply_stimulus(1'b1, "s3_6", r);
`ifdef BTN_POLL_IRQ_EN
        check_output("irq_held", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check_output("irq_ack_clear", 32'(irq), 32'd0);
`endif

        $display("[TB] stalled read");
        waitreq = 1'b1;
        wait_read_rise(r1);
        check_output("s4_seen", 32'(r1 > 0), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("s4_hold", 32'(avm_read), 32'd1);
        end
        check_output("s4_overrun", 32'(overrun), 32'd1);
        waitreq = 1'b0;
        wait_read_rise(r2);
        check_output("s4_followup", 32'(r2 - r1), 32'd13);
        wait_read_rise(r3);
        check_output("s4_next_tick", 32'(r3 - r1), 32'd16);
        wait_read_rise(r);
        check_output("s4_no_extra", 32'(r - r1), 32'd24);
        check_output("s4_level_kept", 32'(btn_level), 32'd1);

        $display("[TB] reset during read");
        wait_read_rise(r);
        check_output("s5_seen", 32'(r > 0), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_output("s5_async_reset",
                        32'({avm_read, avm_address, btn_level, btn_press, btn_release, overrun}), 32'd0);
        model_level = 1'b0;
        model_cnt   = 0;
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b1, "s5a", r1);
        check_output("s5_first_read", 32'(r1), 32'(POLL + 1));
        apply_stimulus(1'b1, "s5b", r);
`ifdef BTN_POLL_IRQ_EN
        irq_ack = 1'b1;
`endif
        apply_stimulus(1'b1, "s5c", r);
`ifdef BTN_POLL_IRQ_EN
        check_output("irq_ack_no_press", 32'(irq), 32'd0);
        irq_ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
